id_stage_controller: RTL and testbench
======================================

// Module: id_stage_controller
// PURPOSE
// - Decode-stage sequencer: classifies each fetched instruction, drives imm_src to the
//   immediate extender, and captures imm_ext plus decode fields into the ID/EX register.
// - Valid/ready handshake to IF and EX stages; inserts load-use bubbles; honours flush.
// PARAMETERS
// - XLEN         32  datapath width (pc, imm)
// - STALL_CNT_W  16  width of saturating load-use bubble counter
// PORTS
// - clk          in   1     rising-edge clock
// - rst_n        in   1     asynchronous active-low reset
// - if_valid     in   1     IF/ID holds an instruction
// - if_inst      in   32    instruction word
// - if_pc        in   XLEN  instruction PC
// - id_ready     out  1     ID accepts if_inst this cycle
// - imm_src      out  3     to extender: I=000 S=001 B=010 U=011 J=100
// - imm_ext      in   XLEN  from extender (combinational on if_inst/imm_src)
// - flush        in   1     branch/jump redirect: kill ID and ID/EX contents
// - ex_ready     in   1     EX consumes ID/EX register this cycle
// - ex_valid     out  1     ID/EX register valid
// - ex_pc, ex_imm out XLEN  registered PC, immediate
// - ex_rs1, ex_rs2, ex_rd out 5  registered register indices (rd=0 for S/B)
// - ex_mem_read  out  1     registered: instruction is LOAD
// - ex_use_imm   out  1     registered: ALU operand B is immediate
// - stall_cnt    out  STALL_CNT_W  load-use bubbles inserted, saturating
// - illegal_inst out  1     (ILLEGAL_TRAP_EN only) registered illegal flag
// BEHAVIOUR
// - Reset (async, rst_n=0): every registered output 0; stall_cnt 0. imm_src/id_ready are
//   combinational (id_ready=0 while in reset).
// - Opcode map (inst[6:0]) -> imm_src/use_imm/uses_rs1/uses_rs2:
//   0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> 000,1,1,0; 0100011 STORE -> 001,1,1,1;
//   1100011 BRANCH -> 010,0,1,1; 0110111 LUI, 0010111 AUIPC -> 011,1,0,0;
//   1101111 JAL -> 100,1,0,0; 0110011 OP -> 000,0,1,1; anything else = illegal.
// - hazard = ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) |
//   (uses_rs2 & ex_rd==rs2)), evaluated on if_inst.
// - id_ready = !flush & !hazard & (!ex_valid | ex_ready). Transfer when if_valid&id_ready.
// - ID/EX update, priority order each cycle:
//   1 flush          -> ex_valid<=0 (transfer blocked, no count)
//   2 transfer       -> load all ex_* from decode, ex_valid<=1; latency 1 cycle
//   3 hazard & if_valid & (!ex_valid|ex_ready) -> ex_valid<=0 (bubble), stall_cnt+=1
//   4 ex_ready       -> ex_valid<=0
//   5 otherwise      -> hold all ex_* (backpressure)
// - Bubble clears hazard next cycle; one bubble per load-use pair.
// - stall_cnt saturates at all-ones; never wraps.
// - ex_rd forced 0 for STORE/BRANCH; rs1/rs2 fields captured raw regardless of use.
// - Fields other than ex_valid are don't-care when ex_valid=0 but must not change while
//   ex_valid=1 and ex_ready=0.
// - Reset asserted mid-transfer: register cleared immediately, pending transfer lost.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined: illegal opcode is transferred with ex_valid=1,
//   illegal_inst=1, ex_use_imm=0, ex_mem_read=0, ex_rd=0; illegal_inst follows ex_* rules.
// - Undefined: port illegal_inst absent; illegal opcode decoded as OP (R-type), no flag.
// TESTING
// - Reset: rst_n=0 mid-stream -> ex_valid=0, stall_cnt=0 same cycle; id_ready=0.
// - ADDI x1,x0,-5 (0xFFB00093), ex_ready=1 -> imm_src=000, next cycle ex_valid=1,
//   ex_imm=0xFFFFFFFB, ex_rd=1, ex_use_imm=1.
// - LW x5,0(x2) then ADD x6,x5,x7 -> cycle 2 id_ready=0, one bubble (ex_valid=0),
//   ADD issues cycle 3; stall_cnt=1. Same with rd=x0 -> no bubble.
// - ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0, all ex_* stable; resume next.
// - flush=1 with if_valid=1 -> id_ready=0, ex_valid=0 next cycle, stall_cnt unchanged.
// - inst opcode 0x7F: with ILLEGAL_TRAP_EN illegal_inst=1, ex_valid=1; without, no flag.

Source files
------------

// File: rtl/id_stage_controller.sv
// -----------------------------------------------------------------------------
// id_stage_controller
//
// Purpose:
//   Decode-stage sequencer. Classifies the instruction held in IF/ID, tells the
//   immediate extender which format to build (imm_src), and captures the
//   extended immediate plus the decode fields into the ID/EX register. It uses a
//   valid/ready handshake towards IF and EX. It inserts one bubble for each
//   load-use pair and honours a branch/jump flush.
//
// Parameters:
//   XLEN         datapath width of pc and immediate
//   STALL_CNT_W  width of the saturating load-use bubble counter
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   if_valid, if_inst,   IF/ID contents (valid, instruction word, PC)
//   if_pc
//   id_ready             ID accepts if_inst this cycle (combinational)
//   imm_src              extender format I=000 S=001 B=010 U=011 J=100 (comb.)
//   imm_ext              extended immediate from the extender
//   flush                kill the ID and ID/EX contents
//   ex_ready             EX consumes the ID/EX register this cycle
//   ex_valid, ex_pc,     registered ID/EX contents
//   ex_imm, ex_rs1,
//   ex_rs2, ex_rd,
//   ex_mem_read,
//   ex_use_imm
//   stall_cnt            load-use bubbles inserted (saturating)
//   illegal_inst         registered illegal-opcode flag (only present with
//                        ILLEGAL_TRAP_EN defined)
//
// Configuration:
//   ILLEGAL_TRAP_EN      when defined, an unknown opcode is passed to EX with
//                        illegal_inst=1. When undefined, an unknown opcode is
//                        decoded as an OP (R-type) instruction and no flag exists.
// -----------------------------------------------------------------------------
module id_stage_controller #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  input  logic [XLEN-1:0]        if_pc,
  output logic                   id_ready,
  output logic [2:0]             imm_src,
  input  logic [XLEN-1:0]        imm_ext,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_imm,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic                   ex_mem_read,
  output logic                   ex_use_imm,
  output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                   illegal_inst
`endif
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Raw instruction fields
  logic [6:0] opcode_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic [4:0] rd_raw_s;
  logic       unused_inst_bits_s;

  assign opcode_s = if_inst[6:0];
  assign rs1_s    = if_inst[19:15];
  assign rs2_s    = if_inst[24:20];
  assign rd_raw_s = if_inst[11:7];
  // funct3/funct7 are decoded in EX, not here
  assign unused_inst_bits_s = ^{if_inst[31:25], if_inst[14:12]};

  // Decode results
  logic [2:0] dec_imm_src_s;
  logic       dec_use_imm_s;
  logic       dec_uses_rs1_s;
  logic       dec_uses_rs2_s;
  logic       dec_mem_read_s;
  logic       dec_rd_zero_s;
  logic       dec_illegal_s;
  logic [4:0] dec_rd_s;

  // ID/EX register state
  logic                   ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]        ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]        ex_imm_q,      ex_imm_d;
  logic [4:0]             ex_rs1_q,      ex_rs1_d;
  logic [4:0]             ex_rs2_q,      ex_rs2_d;
  logic [4:0]             ex_rd_q,       ex_rd_d;
  logic                   ex_mem_read_q, ex_mem_read_d;
  logic                   ex_use_imm_q,  ex_use_imm_d;
  logic                   ex_illegal_q,  ex_illegal_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  // Handshake helpers
  logic hazard_s;
  logic ex_free_s;
  logic xfer_s;
  logic bubble_s;

  // Opcode classification: immediate format, operand use and destination rules
  always_comb begin
    dec_imm_src_s  = IMM_I;
    dec_use_imm_s  = 1'b0;
    dec_uses_rs1_s = 1'b1;
    dec_uses_rs2_s = 1'b1;
    dec_mem_read_s = 1'b0;
    dec_rd_zero_s  = 1'b0;
    dec_illegal_s  = 1'b0;
    case (opcode_s)
      OPC_OP_IMM, OPC_JALR: begin
        dec_use_imm_s  = 1'b1;
        dec_uses_rs2_s = 1'b0;
      end
      OPC_LOAD: begin
        dec_use_imm_s  = 1'b1;
        dec_uses_rs2_s = 1'b0;
        dec_mem_read_s = 1'b1;
      end
      OPC_STORE: begin
        dec_imm_src_s = IMM_S;
        dec_use_imm_s = 1'b1;
        dec_rd_zero_s = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm_src_s = IMM_B;
        dec_rd_zero_s = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm_src_s  = IMM_U;
        dec_use_imm_s  = 1'b1;
        dec_uses_rs1_s = 1'b0;
        dec_uses_rs2_s = 1'b0;
      end
      OPC_JAL: begin
        dec_imm_src_s  = IMM_J;
        dec_use_imm_s  = 1'b1;
        dec_uses_rs1_s = 1'b0;
        dec_uses_rs2_s = 1'b0;
      end
      OPC_OP: begin
        dec_use_imm_s = 1'b0;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        // Trapped instruction reads nothing, so it never raises a hazard
        dec_illegal_s  = 1'b1;
        dec_uses_rs1_s = 1'b0;
        dec_uses_rs2_s = 1'b0;
        dec_rd_zero_s  = 1'b1;
`else
        // Unknown opcode falls through as an R-type OP
        dec_illegal_s  = 1'b0;
`endif
      end
    endcase
  end

  assign dec_rd_s = dec_rd_zero_s ? 5'd0 : rd_raw_s;
  assign imm_src  = dec_imm_src_s;

  // Load-use hazard against the instruction currently in ID/EX
  assign hazard_s = ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) &
                    ((dec_uses_rs1_s & (ex_rd_q == rs1_s)) |
                     (dec_uses_rs2_s & (ex_rd_q == rs2_s)));

  assign ex_free_s = ~ex_valid_q | ex_ready;
  // rst_n gating keeps id_ready low while reset is asserted
  assign id_ready  = rst_n & ~flush & ~hazard_s & ex_free_s;
  assign xfer_s    = if_valid & id_ready;
  assign bubble_s  = hazard_s & if_valid & ex_free_s;

  // ID/EX next state in priority order: flush, transfer, bubble, drain, hold
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_mem_read_d = ex_mem_read_q;
    ex_use_imm_d  = ex_use_imm_q;
    ex_illegal_d  = ex_illegal_q;
    stall_cnt_d   = stall_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (xfer_s) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = if_pc;
      ex_imm_d      = imm_ext;
      ex_rs1_d      = rs1_s;
      ex_rs2_d      = rs2_s;
      ex_rd_d       = dec_rd_s;
      ex_mem_read_d = dec_mem_read_s;
      ex_use_imm_d  = dec_use_imm_s;
      ex_illegal_d  = dec_illegal_s;
    end else if (bubble_s) begin
      ex_valid_d = 1'b0;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + STALL_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      // Backpressure: every field holds
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX register and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_mem_read_q <= 1'b0;
      ex_use_imm_q  <= 1'b0;
      ex_illegal_q  <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_use_imm_q  <= ex_use_imm_d;
      ex_illegal_q  <= ex_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_mem_read = ex_mem_read_q;
  assign ex_use_imm  = ex_use_imm_q;
  assign stall_cnt   = stall_cnt_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_inst = ex_illegal_q;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = ex_illegal_q;
`endif

endmodule

// File: tb/tb_id_stage_controller.sv
module tb_id_stage_controller;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm_ext;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_use_imm;
  logic [15:0] stall_cnt;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_inst;
`endif

  int tests_run;
  int tests_failed;

  id_stage_controller #(.XLEN(32), .STALL_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .imm_src     (imm_src),
    .imm_ext     (imm_ext),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_use_imm  (ex_use_imm),
    .stall_cnt   (stall_cnt)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_inst(illegal_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one input vector and let combinational outputs settle
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] imm, input logic er, input logic fl);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    imm_ext  = imm;
    ex_ready = er;
    flush    = fl;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_id_ready",  32'(id_ready),  32'd0);
    chk("rst_ex_valid",  32'(ex_valid),  32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ADDI x1,x0,-5
    drive(1'b1, 32'hFFB0_0093, 32'h100, 32'hFFFF_FFFB, 1'b1, 1'b0);
    chk("addi_imm_src",  32'(imm_src),  32'd0);
    chk("addi_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("addi_ex_valid",   32'(ex_valid),    32'd1);
    chk("addi_ex_imm",     ex_imm,           32'hFFFF_FFFB);
    chk("addi_ex_rd",      32'(ex_rd),       32'd1);
    chk("addi_ex_use_imm", 32'(ex_use_imm),  32'd1);
    chk("addi_ex_pc",      ex_pc,            32'h100);
    chk("addi_mem_read",   32'(ex_mem_read), 32'd0);

    // LW x5,0(x2) followed by dependent ADD x6,x5,x7
    drive(1'b1, 32'h0001_2283, 32'h104, 32'h0, 1'b1, 1'b0);
    chk("lw_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("lw_ex_rd",       32'(ex_rd),       32'd5);
    chk("lw_ex_mem_read", 32'(ex_mem_read), 32'd1);
    drive(1'b1, 32'h0072_8333, 32'h108, 32'h0, 1'b1, 1'b0);
    chk("lu_id_ready_hazard", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid),  32'd0);
    chk("lu_stall_cnt",    32'(stall_cnt), 32'd1);
    chk("lu_id_ready_clr", 32'(id_ready),  32'd1);
    tick();
    chk("add_ex_valid",   32'(ex_valid),   32'd1);
    chk("add_ex_rd",      32'(ex_rd),      32'd6);
    chk("add_ex_rs1",     32'(ex_rs1),     32'd5);
    chk("add_ex_rs2",     32'(ex_rs2),     32'd7);
    chk("add_ex_use_imm", 32'(ex_use_imm), 32'd0);
    chk("add_ex_pc",      ex_pc,           32'h108);
    chk("add_stall_cnt",  32'(stall_cnt),  32'd1);

    // LW x0 then ADD x6,x0,x7: rd=x0 never stalls
    drive(1'b1, 32'h0001_2003, 32'h10C, 32'h0, 1'b1, 1'b0);
    tick();
    chk("lw0_mem_read", 32'(ex_mem_read), 32'd1);
    chk("lw0_ex_rd",    32'(ex_rd),       32'd0);
    drive(1'b1, 32'h0070_0333, 32'h110, 32'h0, 1'b1, 1'b0);
    chk("x0_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("x0_ex_valid",  32'(ex_valid),  32'd1);
    chk("x0_ex_pc",     ex_pc,          32'h110);
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // SW x7,12(x5) then backpressure for 3 cycles with BEQ waiting
    drive(1'b1, 32'h0072_A623, 32'h114, 32'h0000_000C, 1'b1, 1'b0);
    chk("sw_imm_src", 32'(imm_src), 32'd1);
    tick();
    chk("sw_ex_rd",      32'(ex_rd),      32'd0);
    chk("sw_ex_use_imm", 32'(ex_use_imm), 32'd1);
    chk("sw_ex_imm",     ex_imm,          32'h0000_000C);
    chk("sw_ex_rs2",     32'(ex_rs2),     32'd7);
    drive(1'b1, 32'h0020_8463, 32'h118, 32'h0000_0008, 1'b0, 1'b0);
    chk("beq_imm_src",     32'(imm_src),  32'd2);
    chk("bp_id_ready_pre", 32'(id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ex_valid", 32'(ex_valid), 32'd1);
      chk("bp_ex_pc",    ex_pc,         32'h114);
      chk("bp_ex_imm",   ex_imm,        32'h0000_000C);
      chk("bp_ex_rd",    32'(ex_rd),    32'd0);
      chk("bp_id_ready", 32'(id_ready), 32'd0);
    end
    drive(1'b1, 32'h0020_8463, 32'h118, 32'h0000_0008, 1'b1, 1'b0);
    chk("resume_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("beq_ex_pc",      ex_pc,           32'h118);
    chk("beq_ex_rd",      32'(ex_rd),      32'd0);
    chk("beq_ex_use_imm", 32'(ex_use_imm), 32'd0);
    chk("beq_ex_rs1",     32'(ex_rs1),     32'd1);
    chk("beq_ex_rs2",     32'(ex_rs2),     32'd2);
    chk("beq_ex_imm",     ex_imm,          32'h0000_0008);

    // Flush overrides a pending load-use bubble: no count
    drive(1'b1, 32'h0001_2283, 32'h11C, 32'h0, 1'b1, 1'b0);
    tick();
    chk("lw2_mem_read", 32'(ex_mem_read), 32'd1);
    drive(1'b1, 32'h0072_8333, 32'h120, 32'h0, 1'b1, 1'b1);
    chk("flush_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("flush_ex_valid",  32'(ex_valid),  32'd0);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'd1);

    // LUI x3 and JAL x1
    drive(1'b1, 32'h1234_51B7, 32'h124, 32'h1234_5000, 1'b1, 1'b0);
    chk("lui_imm_src", 32'(imm_src), 32'd3);
    tick();
    chk("lui_ex_valid",   32'(ex_valid),   32'd1);
    chk("lui_ex_rd",      32'(ex_rd),      32'd3);
    chk("lui_ex_use_imm", 32'(ex_use_imm), 32'd1);
    chk("lui_ex_imm",     ex_imm,          32'h1234_5000);
    drive(1'b1, 32'h0080_00EF, 32'h128, 32'h0000_0008, 1'b1, 1'b0);
    chk("jal_imm_src", 32'(imm_src), 32'd4);
    tick();
    chk("jal_ex_rd",      32'(ex_rd),      32'd1);
    chk("jal_ex_use_imm", 32'(ex_use_imm), 32'd1);

    // LW x7 then ADDI with rs2 field = 7: rs2 unused, no stall
    drive(1'b1, 32'h0001_2383, 32'h12C, 32'h0, 1'b1, 1'b0);
    tick();
    chk("lw7_ex_rd", 32'(ex_rd), 32'd7);
    drive(1'b1, 32'h0070_0093, 32'h130, 32'h0000_0007, 1'b1, 1'b0);
    chk("addi7_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("addi7_ex_pc",     ex_pc,          32'h130);
    chk("addi7_stall_cnt", 32'(stall_cnt), 32'd1);
    // LW x7 then ADD x6,x5,x7: rs2 hazard
    drive(1'b1, 32'h0001_2383, 32'h134, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0072_8333, 32'h138, 32'h0, 1'b1, 1'b0);
    chk("rs2_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("rs2_bubble_valid", 32'(ex_valid),  32'd0);
    chk("rs2_stall_cnt",    32'(stall_cnt), 32'd2);
    tick();
    chk("rs2_add_valid", 32'(ex_valid), 32'd1);
    chk("rs2_add_pc",    ex_pc,         32'h138);

    // Unknown opcode 0x7F with rd field = 3
    drive(1'b1, 32'h0000_01FF, 32'h13C, 32'h0, 1'b1, 1'b0);
    chk("ill_imm_src", 32'(imm_src), 32'd0);
    tick();
    chk("ill_ex_valid",   32'(ex_valid),    32'd1);
    chk("ill_ex_use_imm", 32'(ex_use_imm),  32'd0);
    chk("ill_mem_read",   32'(ex_mem_read), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_flag",  32'(illegal_inst), 32'd1);
    chk("ill_ex_rd", 32'(ex_rd),        32'd0);
`else
    chk("ill_ex_rd", 32'(ex_rd),        32'd3);
`endif
    drive(1'b1, 32'h0070_0093, 32'h140, 32'h0000_0007, 1'b1, 1'b0);
    tick();
    chk("post_ill_pc", ex_pc, 32'h140);
`ifdef ILLEGAL_TRAP_EN
    chk("post_ill_flag", 32'(illegal_inst), 32'd0);
`endif

    // Reset asserted mid-stream
    drive(1'b1, 32'h0001_2283, 32'h144, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    drive(1'b1, 32'h0070_0093, 32'h148, 32'h0000_0007, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ex_valid",  32'(ex_valid),  32'd0);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_rst_id_ready",  32'(id_ready),  32'd0);
    tick();
    chk("mid_rst_hold_valid", 32'(ex_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
